// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the unified-memory arbiter.
//   state_e : arbiter sequencer states (IDLE / ACCESS / RESP)
//   owner_e : which requester currently owns the memory (INST / DATA)
//   other_owner() : returns the opposite requester, used for round-robin ties
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_INST) ? OWN_DATA : OWN_INST;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: purely combinational two-requester round-robin picker.
//   req_inst, req_data : pending requests
//   last_owner         : owner of the previous grant (held by the parent)
//   grant_valid        : at least one request is pending
//   owner              : requester to grant; on a tie, the one that did not
//                        win last time
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic   req_inst,
    input  logic   req_data,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e owner
);

    // Pick the owner from the request pattern and the previous winner.
    always_comb begin
        grant_valid = req_inst | req_data;
        owner       = OWN_INST;
        case ({req_inst, req_data})
            2'b10:   owner = OWN_INST;
            2'b01:   owner = OWN_DATA;
            2'b11:   owner = other_owner(last_owner);
            default: owner = OWN_INST;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch port (I_*)
// and the load/store port (D_*).
//   CLK, RST_F           : clock, synchronous active-high reset
//   I_REQ/I_ADDR         : fetch request, held until I_DONE
//   I_GNT/I_DONE/I_RDATA : fetch owns memory / completion pulse / fetched word
//   D_REQ/D_WE/D_ADDR/D_WDATA : data request, held until D_DONE
//   D_GNT/D_DONE/D_RDATA : data owns memory / completion pulse / loaded word
//   MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA/MEM_RDATA : memory array interface
//   BUSY                 : an access is in progress
// Every output is a flop or a decode of flopped state; no input reaches an
// output combinationally.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
)
(
    input  logic              CLK,
    input  logic              RST_F,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_DONE,
    output logic [DATA_W-1:0] I_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_DONE,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    owner_e            last_owner_q, last_owner_d;
    owner_e            owner_q,      owner_d;
    logic              we_cap_q,     we_cap_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,    i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;

    logic   arb_valid;
    owner_e arb_owner;

    rr_arb2 u_rr_arb2 (
        .req_inst    (I_REQ),
        .req_data    (D_REQ),
        .last_owner  (last_owner_q),
        .grant_valid (arb_valid),
        .owner       (arb_owner)
    );

    // Next-state and capture logic for the IDLE -> ACCESS -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        we_cap_d     = we_cap_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d      = arb_owner;
                    last_owner_d = arb_owner;
                    cnt_d        = {CNT_W{1'b0}};
                    mem_addr_d   = (arb_owner == OWN_DATA) ? D_ADDR : I_ADDR;
                    // Fetches are always reads whatever D_WE happens to be.
                    we_cap_d     = (arb_owner == OWN_DATA) & D_WE;
                    mem_wdata_d  = D_WDATA;
                    state_d      = ST_ACCESS;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    // MEM_RDATA is only valid in the final ACCESS cycle.
                    if (!we_cap_q) begin
                        if (owner_q == OWN_DATA) begin
                            d_rdata_d = MEM_RDATA;
                        end else begin
                            i_rdata_d = MEM_RDATA;
                        end
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST_F) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            last_owner_q <= OWN_INST;
            owner_q      <= OWN_INST;
            we_cap_q     <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {DATA_W{1'b0}};
            i_rdata_q    <= {DATA_W{1'b0}};
            d_rdata_q    <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            we_cap_q     <= we_cap_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign BUSY      = (state_q != ST_IDLE);
    assign MEM_EN    = (state_q == ST_ACCESS);
    assign MEM_WE    = (state_q == ST_ACCESS) & we_cap_q;
    assign MEM_ADDR  = mem_addr_q;
    assign MEM_WDATA = mem_wdata_q;
    assign I_GNT     = BUSY & (owner_q == OWN_INST);
    assign D_GNT     = BUSY & (owner_q == OWN_DATA);
    assign I_DONE    = (state_q == ST_RESP) & (owner_q == OWN_INST);
    assign D_DONE    = (state_q == ST_RESP) & (owner_q == OWN_DATA);
    assign I_RDATA   = i_rdata_q;
    assign D_RDATA   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter. Requesters
// work from per-port operation queues; a transaction-level model (countdown
// of remaining cycles per access, memory array, expected read registers)
// predicts every output cycle by cycle.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int W  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_f, i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_gnt, i_done, d_gnt, d_done, mem_en, mem_we, busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) u_dut (
        .CLK(clk), .RST_F(rst_f),
        .I_REQ(i_req), .I_ADDR(i_addr), .I_GNT(i_gnt), .I_DONE(i_done), .I_RDATA(i_rdata),
        .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
        .D_GNT(d_gnt), .D_DONE(d_done), .D_RDATA(d_rdata),
        .MEM_EN(mem_en), .MEM_WE(mem_we), .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata),
        .MEM_RDATA(mem_rdata), .BUSY(busy)
    );

    // Zero-wait-state build, exercised by a short directed load.
    logic          rst0, i_req0, d_req0, d_we0;
    logic [AW-1:0] i_addr0, d_addr0, mem_addr0;
    logic [DW-1:0] d_wdata0, mem_rdata0, i_rdata0, d_rdata0, mem_wdata0;
    logic          i_gnt0, i_done0, d_gnt0, d_done0, mem_en0, mem_we0, busy0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u_dut0 (
        .CLK(clk), .RST_F(rst0),
        .I_REQ(i_req0), .I_ADDR(i_addr0), .I_GNT(i_gnt0), .I_DONE(i_done0), .I_RDATA(i_rdata0),
        .D_REQ(d_req0), .D_WE(d_we0), .D_ADDR(d_addr0), .D_WDATA(d_wdata0),
        .D_GNT(d_gnt0), .D_DONE(d_done0), .D_RDATA(d_rdata0),
        .MEM_EN(mem_en0), .MEM_WE(mem_we0), .MEM_ADDR(mem_addr0), .MEM_WDATA(mem_wdata0),
        .MEM_RDATA(mem_rdata0), .BUSY(busy0)
    );
    assign mem_rdata0 = mem_en0 ? 32'h0000_1234 : 32'hFFFF_0000;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Environment memory (written through the DUT bus) and model memory.
    logic [DW-1:0] env_mem [64];
    logic [DW-1:0] model_mem [64];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } dop_t;
    logic [AW-1:0] i_q [$];
    dop_t          d_q [$];

    // Model: m_rem = cycles left in the current transaction (0 = idle);
    // W+1 access cycles followed by one response cycle.
    int            m_rem = 0;
    bit            m_own = 1'b0, m_last = 1'b0, m_we = 1'b0, m_in_rst = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_irdata = '0, m_drdata = '0;

    bit            gnt_log [$];
    bit            prev_en = 1'b0;
    int            i_start_cyc = 0;

    task automatic model_step();
        if (rst_f) begin
            m_rem = 0; m_last = 1'b0; m_irdata = '0; m_drdata = '0; m_in_rst = 1'b1;
        end else begin
            m_in_rst = 1'b0;
            if (m_rem == 0) begin
                if (i_req || d_req) begin
                    m_own   = (i_req && d_req) ? !m_last : d_req;
                    m_last  = m_own;
                    m_addr  = m_own ? d_addr : i_addr;
                    m_we    = m_own ? d_we : 1'b0;
                    m_wdata = d_wdata;
                    m_rem   = W + 2;
                end
            end else begin
                m_rem--;
                if (m_rem == 1) begin
                    if (m_we) model_mem[m_addr[5:0]] = m_wdata;
                    else if (m_own) m_drdata = model_mem[m_addr[5:0]];
                    else m_irdata = model_mem[m_addr[5:0]];
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit e_en;
        e_en = (m_rem >= 2);
        check_eq("busy", busy, m_rem != 0);
        check_eq("mem_en", mem_en, e_en);
        check_eq("mem_we", mem_we, e_en && m_we);
        check_eq("i_gnt", i_gnt, (m_rem != 0) && !m_own);
        check_eq("d_gnt", d_gnt, (m_rem != 0) && m_own);
        check_eq("i_done", i_done, (m_rem == 1) && !m_own);
        check_eq("d_done", d_done, (m_rem == 1) && m_own);
        check_eq("i_rdata", i_rdata, m_irdata);
        check_eq("d_rdata", d_rdata, m_drdata);
        check_eq("gnt_excl", i_gnt & d_gnt, 0);
        check_eq("done_excl", i_done & d_done, 0);
        if (e_en) check_eq("mem_addr", mem_addr, m_addr);
        if (e_en && m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
        if (m_in_rst) begin
            check_eq("rst_mem_addr", mem_addr, 0);
            check_eq("rst_mem_wdata", mem_wdata, 0);
        end
    endtask

    task automatic drive_requesters();
        if (m_rem == 1 && !m_own) begin void'(i_q.pop_front()); i_req = 1'b0; end
        if (m_rem == 1 && m_own)  begin void'(d_q.pop_front()); d_req = 1'b0; end
        if (!i_req) begin
            if (i_q.size() > 0) begin
                i_req = 1'b1; i_addr = i_q[0]; i_start_cyc = cyc;
            end else begin
                i_addr = 16'($urandom);
            end
        end
        if (!d_req) begin
            if (d_q.size() > 0) begin
                d_req = 1'b1; d_we = d_q[0].we; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
            end else begin
                d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = $urandom;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        mem_rdata = (m_rem == 2) ? env_mem[mem_addr[5:0]] : (32'hBAD0_0000 | {16'h0000, mem_addr});
        if (mem_en && mem_we) env_mem[mem_addr[5:0]] = mem_wdata;
        if (mem_en && !prev_en) gnt_log.push_back(d_gnt);
        prev_en = mem_en;
        check_outputs();
        drive_requesters();
    endtask

    task automatic drain(input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            if (i_q.size() == 0 && d_q.size() == 0 && m_rem == 0) break;
            step();
        end
        check_eq("drain_done", (i_q.size() == 0 && d_q.size() == 0 && m_rem == 0), 1);
    endtask

    task automatic do_reset(input int n);
        rst_f = 1'b1;
        for (int k = 0; k < n; k++) step();
        rst_f = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int en_cnt, we_cnt, done_cyc;
        bit found;
        dop_t op;

        for (int a = 0; a < 64; a++) begin
            env_mem[a] = $urandom;
            model_mem[a] = env_mem[a];
        end
        env_mem[16] = 32'hA5A5_0001; model_mem[16] = 32'hA5A5_0001;
        rst_f = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        rst0 = 1'b1; i_req0 = 1'b0; d_req0 = 1'b0; d_we0 = 1'b0;
        i_addr0 = '0; d_addr0 = '0; d_wdata0 = '0;

        do_reset(3);

        // Single fetch after reset.
        i_q.push_back(16'h0010);
        en_cnt = 0; done_cyc = -1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (mem_en) en_cnt++;
            if (i_done && done_cyc < 0) done_cyc = cyc;
        end
        check_eq("t1_en_cycles", en_cnt, 3);
        check_eq("t1_latency", 64'(done_cyc - i_start_cyc), W + 2);
        check_eq("t1_i_rdata", i_rdata, 32'hA5A5_0001);
        check_eq("t1_d_rdata", d_rdata, 0);

        // Single store.
        op.we = 1'b1; op.addr = 16'h0020; op.wdata = 32'hDEAD_BEEF;
        d_q.push_back(op);
        we_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (mem_we) begin
                we_cnt++;
                check_eq("t2_addr", mem_addr, 16'h0020);
                check_eq("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
            end
        end
        check_eq("t2_we_cycles", we_cnt, 3);
        check_eq("t2_d_rdata", d_rdata, 0);
        check_eq("t2_env_mem", env_mem[32], 32'hDEAD_BEEF);

        // Simultaneous held requests right after reset: strict alternation from DATA.
        do_reset(2);
        gnt_log.delete();
        for (int k = 0; k < 4; k++) begin
            i_q.push_back(16'($urandom_range(0, 63)));
            op.we = 1'b0; op.addr = 16'($urandom_range(0, 63)); op.wdata = $urandom;
            d_q.push_back(op);
        end
        drain(80);
        check_eq("t3_grants", gnt_log.size() >= 4, 1);
        for (int k = 0; k < 4; k++)
            if (k < gnt_log.size()) check_eq("t3_order", gnt_log[k], (k % 2 == 0) ? 1 : 0);

        // Reset in the second ACCESS cycle of a store; the held request retries.
        op.we = 1'b1; op.addr = 16'h0020; op.wdata = 32'h0BAD_F00D;
        d_q.push_back(op);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (m_rem == W + 1 && m_own && m_we) begin found = 1'b1; break; end
        end
        check_eq("t4_reach", found, 1);
        rst_f = 1'b1;
        step();
        rst_f = 1'b0;
        check_eq("t4_en", mem_en, 0);
        check_eq("t4_we", mem_we, 0);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_done", d_done, 0);
        drain(30);
        check_eq("t4_env_mem", env_mem[32], 32'h0BAD_F00D);

        // Back-to-back fetches with I_REQ held through I_DONE.
        i_q.push_back(16'h0005);
        i_q.push_back(16'h0006);
        drain(30);

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 5) == 0 && i_q.size() < 3)
                i_q.push_back(16'($urandom_range(0, 63)));
            if ($urandom_range(0, 5) == 0 && d_q.size() < 3) begin
                op.we = 1'($urandom); op.addr = 16'($urandom_range(0, 63)); op.wdata = $urandom;
                d_q.push_back(op);
            end
            step();
        end
        drain(200);

        // Zero-wait-state load.
        @(posedge clk); @(posedge clk); #1;
        rst0 = 1'b0;
        check_eq("w0_rst_busy", busy0, 0);
        check_eq("w0_rst_rdata", d_rdata0, 0);
        d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 16'h0003;
        @(posedge clk); #1;
        check_eq("w0_access_en", mem_en0, 1);
        check_eq("w0_access_gnt", d_gnt0, 1);
        check_eq("w0_access_addr", mem_addr0, 16'h0003);
        check_eq("w0_access_done", d_done0, 0);
        @(posedge clk); #1;
        check_eq("w0_resp_done", d_done0, 1);
        check_eq("w0_resp_en", mem_en0, 0);
        check_eq("w0_resp_rdata", d_rdata0, 32'h0000_1234);
        d_req0 = 1'b0;
        @(posedge clk); #1;
        check_eq("w0_idle_busy", busy0, 0);
        check_eq("w0_idle_done", d_done0, 0);
        check_eq("w0_idle_rdata", d_rdata0, 32'h0000_1234);
        check_eq("w0_i_rdata", i_rdata0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
